// File: rtl/operand_gate_fifo.sv
`default_nettype none
// ============================================================================
// Module   : operand_gate_fifo
// Brief    : Operand A/B gate with valid/ready handshake, DEPTH-entry FIFO,
//            idle-output mode (zero or hold) and saturating dropped-beat count.
// Revision : 1.0 - initial release
// ============================================================================
module operand_gate_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int GATE_MODE = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(DEPTH);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_count;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_idle_a;
    logic [WIDTH-1:0]   w_idle_b;

    // in_ready looks only at registered occupancy: a full FIFO refuses even
    // when a pop happens in the same cycle.
    assign in_ready  = enable ? (r_count < c_DEPTH) : 1'b1;
    assign out_valid = (r_count != '0);
    assign w_push    = enable & in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = ~enable & in_valid;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {a_in, b_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_W'(1);
                2'b01:   r_count <= r_count - c_OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;

    generate
        if (GATE_MODE != 0) begin : g_hold
            logic [WIDTH-1:0] r_hold_a;
            logic [WIDTH-1:0] r_hold_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold_a <= '0;
                    r_hold_b <= '0;
                end else if (w_pop) begin
                    r_hold_a <= w_head[2*WIDTH-1:WIDTH];
                    r_hold_b <= w_head[WIDTH-1:0];
                end
            end

            assign w_idle_a = r_hold_a;
            assign w_idle_b = r_hold_b;
        end else begin : g_zero
            assign w_idle_a = '0;
            assign w_idle_b = '0;
        end
    endgenerate

    assign a_out = out_valid ? w_head[2*WIDTH-1:WIDTH] : w_idle_a;
    assign b_out = out_valid ? w_head[WIDTH-1:0]       : w_idle_b;

endmodule
`default_nettype wire

// File: doc/operand_gate_fifo.md
Name: operand_gate_fifo

Overview:
- Parametrised successor to the operand enable/isolation block: gates two operand buses (A, B) ahead of a downstream arithmetic/compare datapath.
- Adds valid/ready handshaking, a DEPTH-entry operand FIFO, a selectable idle-output mode (zero or hold) and a saturating count of dropped beats.
- Enabled beats are queued and presented in order. Disabled beats are consumed and discarded so downstream logic sees no toggling.

Parameters:
- WIDTH, 4, operand width in bits (applies to both A and B)
- DEPTH, 2, FIFO entries; power of two, >= 2
- GATE_MODE, 0, idle output value: 0 = drive zeros, 1 = hold last popped operands
- CNT_W, 8, width of dropped-beat counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = accept operands into FIFO; 0 = discard incoming operands
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  block can take a beat this cycle
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- a_out  out  WIDTH  operand A to datapath
- b_out  out  WIDTH  operand B to datapath
- drop_cnt  out  CNT_W  beats discarded while enable = 0, saturating

Behaviour:
- Reset (rst_n = 0, asynchronous): FIFO empty, out_valid = 0, a_out/b_out = 0, hold registers = 0, drop_cnt = 0, pointers = 0. in_ready follows the rules below using the reset count (not forced low).
- in_ready
  - enable = 1: in_ready = (count < DEPTH). Depends only on registered count, not on out_ready, so a full FIFO refuses a push even when a pop occurs the same cycle.
  - enable = 0: in_ready = 1.
- Push: enable & in_valid & in_ready, on the clock edge. Writes {a_in, b_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Drop: ~enable & in_valid.
  - Beat is consumed and not stored.
  - drop_cnt increments by 1 and saturates at 2^CNT_W - 1 (no wrap).
- Pop: out_valid & out_ready. Advances rd_ptr modulo DEPTH.
  - GATE_MODE = 1: the popped entry is copied into the hold registers.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at any non-full, non-empty count. When empty, push only; the popped data is never the same-cycle input.
- Latency: a beat pushed at edge N appears with out_valid = 1 after edge N (one cycle, no combinational bypass).
- out_valid = (count != 0), registered-derived.
- a_out/b_out
  - out_valid = 1: FIFO head entry.
  - out_valid = 0, GATE_MODE = 0: all zeros.
  - out_valid = 0, GATE_MODE = 1: hold registers, i.e. the last popped pair (0 after reset).
- Enable deassertion: does not flush. Entries already queued drain normally via out_ready; only new beats are dropped. Enable may toggle every cycle.
- Output stability: while out_valid = 1 and out_ready = 0, a_out/b_out/out_valid are held stable.
- Reset mid-operation: all queued entries are lost immediately; no partial pop completes.
- Occupancy: count is clog2(DEPTH)+1 bits, range 0..DEPTH.

Test Plan:
- Reset, then enable = 1, push A = 4'b0101, B = 4'b1001 with out_ready = 0 -> next cycle out_valid = 1, a_out = 0101, b_out = 1001; held stable for 3 cycles; pop -> out_valid = 0, outputs 0000 (GATE_MODE = 0).
- enable = 1, out_ready = 0, push pairs (0001,1110), (0010,1101) -> in_ready = 0 after the second push. A third offered pair (0011,1100) is not taken even with out_ready = 1 that cycle. Pops return the pairs in order.
- enable = 0, in_valid = 1 for 5 cycles with (0100,1011) -> in_ready = 1, out_valid stays 0, drop_cnt = 5. With CNT_W = 3, 9 drops -> drop_cnt = 7 (saturated).
- Queue (0110,1101), then drop enable while out_ready = 0 -> entry retained. Raise out_ready -> (0110,1101) delivered. Concurrent in_valid beats dropped and counted.
- GATE_MODE = 1: push/pop (1000,1000) -> after pop, out_valid = 0 and a_out/b_out stay 1000/1000 until the next pop.
- Fill FIFO to 2 entries, assert rst_n = 0 mid-cycle -> out_valid = 0, a_out/b_out = 0, drop_cnt = 0 immediately (asynchronous). After release, the first push (0101,1100) pops with no stale data.
